// File: rtl/ula_multiciclo.sv
// rtl/ula_multiciclo.sv - multi-cycle ULA with iterative shift-add multiply and restoring divide
module ula_multiciclo #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ULA_control,
  input  logic [WIDTH-1:0] entrada_01,
  input  logic [WIDTH-1:0] entrada_02,
  output logic [WIDTH-1:0] ULA_result,
  output logic [WIDTH-1:0] hi_result,
  output logic             Zero,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [WIDTH-1:0]   opa, opa_n;
  logic [WIDTH-1:0]   opb, opb_n;
  // Shared iteration register: MUL keeps {partial high, remaining multiplier},
  // DIV keeps {partial remainder, dividend bits still to shift in / quotient}.
  logic [2*WIDTH-1:0] work, work_n;
  logic [WIDTH-1:0]   lo_n, hi_n;
  logic               dbz_n, done_n;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic               last_iter;

  // One iteration of each long operation, computed from the current work register
  always_comb begin
    mul_sum   = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opa} : '0);
    mul_next  = {mul_sum, work[WIDTH-1:1]};
    // Remainder stays below the divisor, so the trial difference fits WIDTH bits when it is kept
    div_ge    = work[2*WIDTH-1:WIDTH-1] >= {1'b0, opb};
    div_diff  = work[2*WIDTH-2:WIDTH-1] - opb;
    div_next  = div_ge ? {div_diff, work[WIDTH-2:0], 1'b1}
                       : {work[2*WIDTH-2:0], 1'b0};
    last_iter = (cnt == CNT_W'(WIDTH - 1));
  end

  // Next-state and next-result logic
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    opa_n   = opa;
    opb_n   = opb;
    work_n  = work;
    lo_n    = ULA_result;
    hi_n    = hi_result;
    dbz_n   = div_by_zero;
    done_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          opa_n  = entrada_01;
          opb_n  = entrada_02;
          cnt_n  = '0;
          hi_n   = '0;
          dbz_n  = 1'b0;
          done_n = 1'b1;
          case (ULA_control)
            OP_AND: lo_n = entrada_01 & entrada_02;
            OP_OR:  lo_n = entrada_01 | entrada_02;
            OP_ADD: lo_n = entrada_01 + entrada_02;
            OP_NOR: lo_n = ~(entrada_01 | entrada_02);
            OP_SUB: lo_n = entrada_01 - entrada_02;
            OP_SLT: lo_n = {{(WIDTH-1){1'b0}}, ($signed(entrada_01) < $signed(entrada_02))};
            OP_MUL: begin
              lo_n    = ULA_result;
              hi_n    = hi_result;
              dbz_n   = div_by_zero;
              done_n  = 1'b0;
              work_n  = {{WIDTH{1'b0}}, entrada_02};
              state_n = S_MUL;
            end
            OP_DIV: begin
              if (entrada_02 == '0) begin
                lo_n  = '1;
                hi_n  = entrada_01;
                dbz_n = 1'b1;
              end else begin
                lo_n    = ULA_result;
                hi_n    = hi_result;
                dbz_n   = div_by_zero;
                done_n  = 1'b0;
                work_n  = {{WIDTH{1'b0}}, entrada_01};
                state_n = S_DIV;
              end
            end
            default: lo_n = ULA_result;
          endcase
        end
      end
      S_MUL: begin
        work_n = mul_next;
        cnt_n  = cnt + CNT_W'(1);
        if (last_iter) begin
          lo_n    = mul_next[WIDTH-1:0];
          hi_n    = mul_next[2*WIDTH-1:WIDTH];
          dbz_n   = 1'b0;
          done_n  = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_DIV: begin
        work_n = div_next;
        cnt_n  = cnt + CNT_W'(1);
        if (last_iter) begin
          lo_n    = div_next[WIDTH-1:0];
          hi_n    = div_next[2*WIDTH-1:WIDTH];
          dbz_n   = 1'b0;
          done_n  = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, operand and result registers; reset abandons any operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      opa         <= '0;
      opb         <= '0;
      work        <= '0;
      ULA_result  <= '0;
      hi_result   <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      opa         <= opa_n;
      opb         <= opb_n;
      work        <= work_n;
      ULA_result  <= lo_n;
      hi_result   <= hi_n;
      div_by_zero <= dbz_n;
      done        <= done_n;
    end
  end

  assign busy = (state != S_IDLE);
  assign Zero = (ULA_result == '0);

endmodule

// File: tb/tb_ula_multiciclo.sv
// tb/tb_ula_multiciclo.sv - randomized self-checking bench for ula_multiciclo
module tb_ula_multiciclo;

  logic        clk = 1'b0;
  logic        reset;
  logic        start32, start8;
  logic [2:0]  ctl32, ctl8;
  logic [31:0] a32, b32, lo32, hi32;
  logic [7:0]  a8, b8, lo8, hi8;
  logic        z32, busy32, done32, dbz32;
  logic        z8, busy8, done8, dbz8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ula_multiciclo #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .ULA_control(ctl32),
    .entrada_01(a32), .entrada_02(b32), .ULA_result(lo32), .hi_result(hi32),
    .Zero(z32), .busy(busy32), .done(done32), .div_by_zero(dbz32)
  );

  ula_multiciclo #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .ULA_control(ctl8),
    .entrada_01(a8), .entrada_02(b8), .ULA_result(lo8), .hi_result(hi8),
    .Zero(z8), .busy(busy8), .done(done8), .div_by_zero(dbz8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic on w-bit unsigned/signed values
  task automatic model(input int w, input logic [2:0] op, input logic [63:0] a_in, input logic [63:0] b_in,
                       output logic [63:0] lo, output logic [63:0] hi, output logic dbz);
    logic [63:0]  mask, a, b;
    logic [127:0] prod;
    longint       sa, sb;
    mask = (64'd1 << w) - 64'd1;
    a    = a_in & mask;
    b    = b_in & mask;
    sa   = $signed(a << (64 - w)) >>> (64 - w);
    sb   = $signed(b << (64 - w)) >>> (64 - w);
    hi   = 64'd0;
    dbz  = 1'b0;
    case (op)
      3'd0: lo = a & b;
      3'd1: lo = a | b;
      3'd2: lo = a + b;
      3'd3: begin
        prod = {64'd0, a} * {64'd0, b};
        lo   = prod[63:0];
        hi   = 64'(prod >> w);
      end
      3'd4: lo = ~(a | b);
      3'd5: begin
        if (b == 64'd0) begin
          lo = mask; hi = a; dbz = 1'b1;
        end else begin
          lo = a / b; hi = a % b;
        end
      end
      3'd6: lo = a - b;
      default: lo = (sa < sb) ? 64'd1 : 64'd0;
    endcase
    lo = lo & mask;
    hi = hi & mask;
  endtask

  function automatic logic [63:0] g_lo(input int w);   return (w == 8) ? 64'(lo8)   : 64'(lo32);   endfunction
  function automatic logic [63:0] g_hi(input int w);   return (w == 8) ? 64'(hi8)   : 64'(hi32);   endfunction
  function automatic logic        g_z(input int w);    return (w == 8) ? z8    : z32;    endfunction
  function automatic logic        g_busy(input int w); return (w == 8) ? busy8 : busy32; endfunction
  function automatic logic        g_done(input int w); return (w == 8) ? done8 : done32; endfunction
  function automatic logic        g_dbz(input int w);  return (w == 8) ? dbz8  : dbz32;  endfunction

  task automatic run_op(input int w, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input string tag);
    logic [63:0] elo, ehi;
    logic        edbz, multi;
    int          lat, busy_cnt;
    model(w, op, a, b, elo, ehi, edbz);
    multi = (op == 3'd3) || (op == 3'd5 && !edbz);
    @(negedge clk);
    if (w == 8) begin ctl8 = op; a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1; end
    else begin ctl32 = op; a32 = a[31:0]; b32 = b[31:0]; start32 = 1'b1; end
    @(posedge clk); #1;
    start8 = 1'b0; start32 = 1'b0;
    a32 = $urandom; b32 = $urandom; ctl32 = 3'($urandom);
    a8 = 8'($urandom); b8 = 8'($urandom); ctl8 = 3'($urandom);
    lat = 0; busy_cnt = 0;
    while (!g_done(w) && lat < 200) begin
      if (g_busy(w)) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), multi ? 64'(w) : 64'd0);
    check({tag, " busy cycles"}, 64'(busy_cnt), multi ? 64'(w) : 64'd0);
    check({tag, " busy at done"}, 64'(g_busy(w)), 64'd0);
    check({tag, " lo"}, g_lo(w), elo);
    check({tag, " Zero"}, 64'(g_z(w)), 64'(elo == 64'd0));
    if (op != 3'd3) begin
      check({tag, " hi"}, g_hi(w), ehi);
      check({tag, " div_by_zero"}, 64'(g_dbz(w)), 64'(edbz));
    end else begin
      check({tag, " hi"}, g_hi(w), ehi);
    end
    @(posedge clk); #1;
    check({tag, " done single pulse"}, 64'(g_done(w)), 64'd0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] elo, ehi;
    logic        edbz;
    logic [2:0]  op;
    logic [63:0] ra, rb;
    int          n_done, first;

    reset = 1'b1;
    start32 = 1'b0; start8 = 1'b0;
    ctl32 = 3'd0; ctl8 = 3'd0;
    a32 = '0; b32 = '0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset lo", 64'(lo32), 64'd0);
    check("reset hi", 64'(hi32), 64'd0);
    check("reset busy", 64'(busy32), 64'd0);
    check("reset done", 64'(done32), 64'd0);
    check("reset dbz", 64'(dbz32), 64'd0);
    check("reset Zero", 64'(z32), 64'd1);
    @(negedge clk);
    reset = 1'b0;

    run_op(32, 3'd2, 64'd5, 64'd7, "add 5+7");
    run_op(32, 3'd6, 64'd9, 64'd9, "sub 9-9");
    run_op(32, 3'd7, 64'hFFFFFFFF, 64'd1, "slt -1<1");
    run_op(32, 3'd4, 64'd0, 64'd0, "nor 0 0");
    run_op(32, 3'd2, 64'hFFFFFFFF, 64'd1, "add wrap");
    run_op(32, 3'd3, 64'h00010000, 64'h00010000, "mul 2^16 sq");
    run_op(32, 3'd3, 64'hFFFFFFFF, 64'hFFFFFFFF, "mul max sq");
    run_op(32, 3'd5, 64'd100, 64'd7, "div 100/7");
    run_op(32, 3'd5, 64'd55, 64'd0, "div 55/0");

    // Single-cycle op issued every cycle keeps done high
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start32 = 1'b1; ctl32 = 3'd2; a32 = 32'(i * 3); b32 = 32'd10;
      @(posedge clk); #1;
      check("b2b done", 64'(done32), 64'd1);
      check("b2b lo", 64'(lo32), 64'(i * 3 + 10));
    end
    start32 = 1'b0;

    // Start while a MUL is running must be ignored
    model(32, 3'd3, 64'd123456789, 64'd987654, elo, ehi, edbz);
    @(negedge clk);
    start32 = 1'b1; ctl32 = 3'd3; a32 = 32'd123456789; b32 = 32'd987654;
    @(posedge clk); #1;
    start32 = 1'b0;
    n_done = 0; first = -1;
    for (int e = 1; e <= 37; e++) begin
      if (e == 10) begin
        @(negedge clk);
        start32 = 1'b1; ctl32 = 3'd2; a32 = 32'd1; b32 = 32'd1;
      end
      @(posedge clk); #1;
      start32 = 1'b0;
      if (done32) begin
        n_done++;
        if (first < 0) first = e;
      end
    end
    check("ignore done count", 64'(n_done), 64'd1);
    check("ignore latency", 64'(first), 64'd32);
    check("ignore lo", 64'(lo32), elo);
    check("ignore hi", 64'(hi32), ehi);

    for (int i = 0; i < 25; i++) begin
      op = 3'($urandom_range(0, 7));
      ra = 64'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? 64'd0 : (($urandom_range(0, 1) == 0) ? 64'($urandom_range(1, 300)) : 64'($urandom));
      run_op(32, op, ra, rb, "rand32");
    end
    for (int i = 0; i < 15; i++) begin
      op = 3'($urandom_range(0, 7));
      ra = 64'($urandom_range(0, 255));
      rb = ($urandom_range(0, 5) == 0) ? 64'd0 : 64'($urandom_range(0, 255));
      run_op(8, op, ra, rb, "rand8");
    end

    // Asynchronous reset in the middle of a DIV
    run_op(32, 3'd5, 64'd9, 64'd0, "div pre-reset");
    @(negedge clk);
    start32 = 1'b1; ctl32 = 3'd5; a32 = 32'd1000000; b32 = 32'd7;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async rst busy", 64'(busy32), 64'd0);
    check("async rst done", 64'(done32), 64'd0);
    check("async rst lo", 64'(lo32), 64'd0);
    check("async rst hi", 64'(hi32), 64'd0);
    check("async rst dbz", 64'(dbz32), 64'd0);
    check("async rst Zero", 64'(z32), 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_done = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk); #1;
      if (done32) n_done++;
    end
    check("no done after reset", 64'(n_done), 64'd0);

    run_op(32, 3'd2, 64'd2, 64'd2, "add 2+2");
    run_op(8, 3'd3, 64'hFF, 64'hFF, "mul8 FF sq");
    run_op(8, 3'd5, 64'd200, 64'd9, "div8 200/9");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
